// File: rtl/count_stream_checker.sv
// Monitor for a free-running counter stage: continuity/upper-flag check, lock FSM,
// saturating error/wrap counters and upper-high run length. Optional: CSC_STICKY_ERR_EN.
module count_stream_checker #(
  parameter int unsigned W      = 4,
  parameter int unsigned THRESH = 8,
  parameter int unsigned LOCK_N = 4,
  parameter int unsigned CW     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [W-1:0]  count,
  input  logic          upper,
  output logic          locked,
  output logic          err_pulse,
  output logic [CW-1:0] err_cnt,
  output logic [CW-1:0] wrap_cnt,
  output logic [W:0]    high_len,
  output logic          err_sticky
);

  localparam int unsigned GW = 4;
  localparam int unsigned RW = W + 1;

  localparam logic [W-1:0]  CNT_MAX = '1;
  localparam logic [CW-1:0] SAT_MAX = '1;
  localparam logic [RW-1:0] RUN_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  prev_q, prev_d;
  logic [GW-1:0] good_n_q, good_n_d;
  logic [RW-1:0] run_q, run_d;
  logic [RW-1:0] high_len_q, high_len_d;
  logic [CW-1:0] err_cnt_q, err_cnt_d;
  logic [CW-1:0] wrap_cnt_q, wrap_cnt_d;
  logic          locked_q, locked_d;
  logic          err_pulse_q, err_pulse_d;

  logic [W-1:0]  inc_c;
  logic          upper_exp_c;
  logic          good_c;

  assign inc_c       = prev_q + W'(1);
  assign upper_exp_c = (32'(count) >= THRESH);
  assign good_c      = (count == inc_c) && (upper == upper_exp_c);

  // Next-state: everything holds unless en is high; err_pulse drops on any idle edge
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    good_n_d    = good_n_q;
    run_d       = run_q;
    high_len_d  = high_len_q;
    err_cnt_d   = err_cnt_q;
    wrap_cnt_d  = wrap_cnt_q;
    err_pulse_d = 1'b0;

    if (en) begin
      prev_d = count;
      unique case (state_q)
        IDLE: begin
          good_n_d = '0;
          state_d  = SYNC;
        end
        SYNC: begin
          if (good_c) begin
            good_n_d = good_n_q + GW'(1);
            if (good_n_q + GW'(1) == GW'(LOCK_N)) state_d = LOCKED;
          end else begin
            good_n_d = '0;
          end
        end
        LOCKED: begin
          if (!good_c) begin
            err_pulse_d = 1'b1;
            good_n_d    = '0;
            state_d     = SYNC;
            if (err_cnt_q != SAT_MAX) err_cnt_d = err_cnt_q + CW'(1);
          end else if (prev_q == CNT_MAX && count == '0) begin
            if (wrap_cnt_q != SAT_MAX) wrap_cnt_d = wrap_cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase

      // Upper-high run length is independent of lock, but not measured in IDLE
      if (state_q != IDLE) begin
        if (upper) begin
          if (run_q != RUN_MAX) run_d = run_q + RW'(1);
        end else if (run_q != '0) begin
          high_len_d = run_q;
          run_d      = '0;
        end
      end
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      good_n_q    <= '0;
      run_q       <= '0;
      high_len_q  <= '0;
      err_cnt_q   <= '0;
      wrap_cnt_q  <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      good_n_q    <= good_n_d;
      run_q       <= run_d;
      high_len_q  <= high_len_d;
      err_cnt_q   <= err_cnt_d;
      wrap_cnt_q  <= wrap_cnt_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
  assign wrap_cnt  = wrap_cnt_q;
  assign high_len  = high_len_q;

`ifdef CSC_STICKY_ERR_EN
  logic err_sticky_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky_q <= 1'b0;
    end else if (err_pulse_d) begin
      err_sticky_q <= 1'b1;
    end
  end

  assign err_sticky = err_sticky_q;
`else
  assign err_sticky = 1'b0;
`endif

endmodule
